// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: tracks pending writes per register, stalls decode on
// RAW hazards, WAW counter saturation and in-flight capacity, and runs a
// RUN/DRAIN/HALTED control FSM for halt requests.
module rf_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [3:0]  id_src0_addr,
    input  logic [3:0]  id_src1_addr,
    input  logic        id_src0_use,
    input  logic        id_src1_use,
    input  logic [3:0]  id_dst_addr,
    input  logic        id_dst_we,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dst_addr,
    input  logic        flush,
    input  logic        hlt,
    output logic        issue,
    output logic        stall,
    output logic [15:0] busy_vec,
    output logic        halted,
    output logic        err
);

    localparam int unsigned NREG = 16;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [NREG-1:0][CW-1:0]  pend_q, pend_d;
    logic [CW-1:0]            inflight_q, inflight_d;
    logic                     err_q, err_d;
    logic                     halted_q;

    logic src0_raw, src1_raw, dst_track, waw_sat, wb_hit, wb_orphan, cap_full, inc;

    // Hazard and writeback qualification against the current (pre-edge) counters
    assign src0_raw  = id_src0_use && (id_src0_addr != 4'd0) && (pend_q[id_src0_addr] != 2'd0);
    assign src1_raw  = id_src1_use && (id_src1_addr != 4'd0) && (pend_q[id_src1_addr] != 2'd0);
    assign dst_track = id_dst_we && (id_dst_addr != 4'd0);
    assign waw_sat   = dst_track && (pend_q[id_dst_addr] == 2'd3);
    assign wb_hit    = wb_valid && (wb_dst_addr != 4'd0) && (pend_q[wb_dst_addr] != 2'd0);
    assign wb_orphan = wb_valid && (wb_dst_addr != 4'd0) && (pend_q[wb_dst_addr] == 2'd0);
    // A retiring writeback frees a slot in the same cycle, so it relieves capacity
    assign cap_full  = dst_track && (inflight_q == CW'(MAX_INFLIGHT)) && !wb_hit;

    // Issue decision; a same-cycle writeback does not bypass a RAW hazard
    assign issue = id_valid && (state_q == ST_RUN) && !flush
                   && !src0_raw && !src1_raw && !waw_sat && !cap_full;
    assign stall = id_valid && !issue;
    assign inc   = issue && dst_track;

    // Pending counters, in-flight count and sticky error; flush wins over everything
    always_comb begin
        pend_d     = pend_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        if (flush) begin
            pend_d     = '0;
            inflight_d = '0;
        end else begin
            if (wb_hit) begin
                pend_d[wb_dst_addr] = pend_q[wb_dst_addr] - 2'd1;
            end
            if (inc) begin
                pend_d[id_dst_addr] = pend_d[id_dst_addr] + 2'd1;
            end
            case ({inc, wb_hit})
                2'b10:   inflight_d = inflight_q + 2'd1;
                2'b01:   inflight_d = inflight_q - 2'd1;
                default: inflight_d = inflight_q;
            endcase
            if (wb_orphan) begin
                err_d = 1'b1;
            end
        end
        pend_d[0] = '0;
    end

    // Halt control next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hlt) begin
                    state_d = (inflight_q != 2'd0) ? ST_DRAIN : ST_HALTED;
                end
            end
            ST_DRAIN: begin
                if (!hlt) begin
                    state_d = ST_RUN;
                end else if (flush || (inflight_q == 2'd0)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!hlt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, counter and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pend_q     <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            halted_q   <= (state_d == ST_HALTED);
        end
    end

    // Busy vector decoded from the registered counters
    always_comb begin
        busy_vec = '0;
        for (int n = 0; n < int'(NREG); n++) begin
            busy_vec[n] = (pend_q[n] != 2'd0);
        end
    end

    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios plus randomized
// traffic, every cycle compared against a rule-level reference model.
module tb_rf_scoreboard;

    localparam int unsigned MAXI = 3;
    localparam int S_RUN = 0, S_DRAIN = 1, S_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_src0_use, id_src1_use, id_dst_we, wb_valid, flush, hlt;
    logic [3:0]  id_src0_addr, id_src1_addr, id_dst_addr, wb_dst_addr;
    logic        issue, stall, halted, err;
    logic [15:0] busy_vec;

    always #5 clk = ~clk;

    rf_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
        .id_src0_use(id_src0_use), .id_src1_use(id_src1_use),
        .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we),
        .wb_valid(wb_valid), .wb_dst_addr(wb_dst_addr),
        .flush(flush), .hlt(hlt),
        .issue(issue), .stall(stall), .busy_vec(busy_vec),
        .halted(halted), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding-write counts per register, total, mode, error
    int m_pend[16];
    int m_infl;
    int m_st;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 0;
        m_infl = 0;
        m_st   = S_RUN;
        m_err  = 1'b0;
    endtask

    function automatic bit model_issue();
        bit raw, waw, retire, cap;
        int s0, s1, d, w;
        s0 = int'(id_src0_addr); s1 = int'(id_src1_addr);
        d  = int'(id_dst_addr);  w  = int'(wb_dst_addr);
        raw    = (id_src0_use && s0 != 0 && m_pend[s0] > 0) || (id_src1_use && s1 != 0 && m_pend[s1] > 0);
        waw    = id_dst_we && d != 0 && m_pend[d] == 3;
        retire = wb_valid && w != 0 && m_pend[w] > 0;
        cap    = id_dst_we && d != 0 && m_infl == int'(MAXI) && !retire;
        return id_valid && m_st == S_RUN && !flush && !raw && !waw && !cap;
    endfunction

    function automatic logic [15:0] model_busy();
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = (m_pend[i] > 0);
        return b;
    endfunction

    task automatic model_step(input bit did_issue);
        int old_infl, d, w;
        bit retire;
        old_infl = m_infl;
        d = int'(id_dst_addr);
        w = int'(wb_dst_addr);
        retire = wb_valid && w != 0 && m_pend[w] > 0;
        if (flush) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
            m_infl = 0;
        end else begin
            if (retire) begin
                m_pend[w]--; m_infl--;
            end else if (wb_valid && w != 0) begin
                m_err = 1'b1;
            end
            if (did_issue && id_dst_we && d != 0) begin
                m_pend[d]++; m_infl++;
            end
        end
        case (m_st)
            S_RUN:   if (hlt) m_st = (old_infl != 0) ? S_DRAIN : S_HALT;
            S_DRAIN: if (!hlt) m_st = S_RUN; else if (flush || old_infl == 0) m_st = S_HALT;
            default: if (!hlt) m_st = S_RUN;
        endcase
    endtask

    task automatic set_in(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                          input int d, input bit we, input bit wv, input int wd,
                          input bit fl, input bit h);
        id_valid = v;  id_src0_addr = 4'(s0); id_src0_use = u0;
        id_src1_addr = 4'(s1); id_src1_use = u1;
        id_dst_addr = 4'(d); id_dst_we = we;
        wb_valid = wv; wb_dst_addr = 4'(wd); flush = fl; hlt = h;
    endtask

    task automatic idle(input bit h);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
    endtask

    // One clock: compare all outputs with the model, then advance the model at the edge
    task automatic cycle();
        bit ei;
        #1;
        ei = model_issue();
        check("issue",  32'(issue),    32'(ei));
        check("stall",  32'(stall),    32'(id_valid && !ei));
        check("busy",   32'(busy_vec), 32'(model_busy()));
        check("halted", 32'(halted),   32'(m_st == S_HALT));
        check("err",    32'(err),      32'(m_err));
        @(posedge clk);
        model_step(ei);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock
    task automatic do_reset();
        idle(0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_busy",   32'(busy_vec), 32'h0);
        check("rst_halted", 32'(halted),   32'h0);
        check("rst_err",    32'(err),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pick_wb();
        int q[$];
        for (int i = 1; i < 16; i++) if (m_pend[i] > 0) q.push_back(i);
        if (q.size() > 0 && $urandom_range(0, 99) < 85) return q[$urandom_range(0, q.size() - 1)];
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        bit hlt_lvl;
        int seq[3];
        rst_n = 1'b0;
        idle(0);
        model_reset();
        @(negedge clk);
        do_reset();

        // First issue marks R3 busy
        set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        #1 check("r3_issue", 32'(issue), 32'h1);
        cycle();

        // RAW on R3 stalls, also while its writeback is in flight this cycle
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("raw_stall", 32'(stall), 32'h1);
        check("r3_busy", 32'(busy_vec), 32'h0008);
        cycle(); cycle();
        set_in(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        #1 check("raw_no_bypass", 32'(stall), 32'h1);
        cycle();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("wb_clear_busy", 32'(busy_vec), 32'h0);
        check("raw_resume", 32'(issue), 32'h1);
        cycle();

        // Capacity: three writes in flight, fourth stalls until a writeback frees a slot
        seq[0] = 1; seq[1] = 2; seq[2] = 4;
        foreach (seq[k]) begin
            set_in(1, 0, 0, 0, 0, seq[k], 1, 0, 0, 0, 0);
            cycle();
        end
        set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        #1 check("cap_stall", 32'(stall), 32'h1);
        cycle();
        set_in(1, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0);
        #1 check("cap_wb_issue", 32'(issue), 32'h1);
        cycle();
        set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        #1 check("cap_still_full", 32'(stall), 32'h1);
        check("cap_busy", 32'(busy_vec), 32'h0034);
        cycle();
        seq[0] = 2; seq[1] = 4; seq[2] = 5;
        foreach (seq[k]) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, seq[k], 0, 0);
            cycle();
        end

        // R0 is never tracked: issue goes through and no slot is consumed
        set_in(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        #1 check("r0_issue", 32'(issue), 32'h1);
        cycle();
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        #1 check("r0_busy", 32'(busy_vec), 32'h0002);
        cycle();
        set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        #1 check("r0_no_inflight", 32'(issue), 32'h1);
        cycle();

        // Halt with writes pending: drain, then halt, then resume
        idle(1); cycle();
        set_in(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 1);
        #1 check("drain_no_issue", 32'(issue), 32'h0);
        cycle();
        set_in(1, 0, 0, 0, 0, 6, 1, 1, 2, 0, 1); cycle();
        set_in(1, 0, 0, 0, 0, 6, 1, 1, 3, 0, 1); cycle();
        idle(1); cycle();
        set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0);
        #1 check("halted_set", 32'(halted), 32'h1);
        check("halt_no_issue", 32'(issue), 32'h0);
        cycle();
        #1 check("resume_issue", 32'(issue), 32'h1);
        check("resume_run", 32'(halted), 32'h0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0); cycle();

        // Halt withdrawn during drain returns to RUN with counters intact
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
        idle(1); cycle();
        idle(0); cycle();
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        #1 check("drain_abort_busy", 32'(busy_vec), 32'h0002);
        check("drain_abort_issue", 32'(issue), 32'h1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0); cycle();

        // Orphan writeback sets sticky err; R0 writeback is harmless; flush clears
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle();
        #1 check("wb_r0_no_err", 32'(err), 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0); cycle();
        idle(0);
        #1 check("err_set", 32'(err), 32'h1);
        cycle(); cycle();
        #1 check("err_sticky", 32'(err), 32'h1);
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 0);
        #1 check("flush_no_issue", 32'(issue), 32'h0);
        cycle();
        idle(0);
        #1 check("flush_clear", 32'(busy_vec), 32'h0);
        cycle();
        do_reset();

        // Reset in the middle of a drain restarts from RUN, empty
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); cycle();
        set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
        idle(1); cycle();
        do_reset();
        set_in(1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        #1 check("post_rst_issue", 32'(issue), 32'h1);
        cycle();

        // Randomized traffic against the model
        hlt_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                do_reset();
                hlt_lvl = 1'b0;
            end
            if ($urandom_range(0, 99) < 5) hlt_lvl = !hlt_lvl;
            set_in($urandom_range(0, 99) < 80,
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), $urandom_range(0, 99) < 70,
                   $urandom_range(0, 99) < 40, pick_wb(),
                   $urandom_range(0, 99) < 3, hlt_lvl);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
